// File: rtl/attr_residual_sequencer_pkg.sv
// Shared types and arithmetic helpers for the attribute residual sequencer.
//   seq_state_e : sequencer FSM states
//   attr_max    : all-ones value of an attribute lane of the given width
//   attr_add    : lane + signed residual, wrapping or saturating to lane width
// Lane widths up to 31 bits are supported by the helpers.
package attr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } seq_state_e;

  function automatic logic [31:0] attr_max(input int unsigned width);
    if (width >= 32) return '1;
    return (32'd1 << width) - 32'd1;
  endfunction

  // Sum is formed two bits wider than the operands so both underflow below 0
  // and overflow past attr_max are visible before the clamp / wrap.
  function automatic logic [31:0] attr_add(input logic [31:0]        lane,
                                           input logic signed [31:0] resid,
                                           input int unsigned        width,
                                           input bit                 saturate);
    logic signed [33:0] sum;
    logic signed [33:0] max_v;
    sum   = $signed({2'b00, lane}) + $signed({{2{resid[31]}}, resid});
    max_v = $signed({2'b00, attr_max(width)});
    if (!saturate) return sum[31:0] & attr_max(width);
    if (sum < 34'sd0) return '0;
    if (sum > max_v) return max_v[31:0];
    return sum[31:0];
  endfunction

endpackage

// File: rtl/attr_residual_sequencer_if.sv
// Handshake bundle of the attribute residual sequencer.
//   frame control : start, point_count -> ; <- busy, done
//   symbol input  : sym_valid, sym_data -> ; <- sym_ready
//   vector output : <- out_valid, out_attr, out_last ; out_ready ->
// master = upstream/downstream environment, slave = sequencer.
interface attr_residual_sequencer_if #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int ATTR_WIDTH   = 8,
  parameter int NUM_ATTR     = 3,
  parameter int CNT_WIDTH    = 16
);
  logic                           start;
  logic [CNT_WIDTH-1:0]           point_count;
  logic                           busy;
  logic                           done;
  logic                           sym_valid;
  logic                           sym_ready;
  logic [SYMBOL_WIDTH-1:0]        sym_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [NUM_ATTR*ATTR_WIDTH-1:0] out_attr;
  logic                           out_last;

  modport master (
    output start, point_count, sym_valid, sym_data, out_ready,
    input  busy, done, sym_ready, out_valid, out_attr, out_last
  );

  modport slave (
    input  start, point_count, sym_valid, sym_data, out_ready,
    output busy, done, sym_ready, out_valid, out_attr, out_last
  );
endinterface

// File: rtl/attr_residual_sequencer_ext.sv
// Symbol-to-residual conversion (combinational).
//   sym   in  SYMBOL_WIDTH  entropy-decoded residual symbol
//   resid out ATTR_WIDTH    two's-complement residual at lane width
// Wide symbols are truncated to the lane width; narrow symbols are
// sign-extended.
module attr_residual_ext #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int ATTR_WIDTH   = 8
) (
  input  logic [SYMBOL_WIDTH-1:0] sym,
  output logic [ATTR_WIDTH-1:0]   resid
);

  if (SYMBOL_WIDTH >= ATTR_WIDTH) begin : g_trunc
    assign resid = sym[ATTR_WIDTH-1:0];
    if (SYMBOL_WIDTH > ATTR_WIDTH) begin : g_drop
      logic sym_hi_unused;
      assign sym_hi_unused = ^sym[SYMBOL_WIDTH-1:ATTR_WIDTH];
    end
  end else begin : g_sext
    assign resid = {{(ATTR_WIDTH-SYMBOL_WIDTH){sym[SYMBOL_WIDTH-1]}}, sym};
  end

endmodule

// File: rtl/attr_residual_sequencer.sv
// Attribute residual sequencer: groups residual symbols into per-point
// attribute vectors, adds each residual to the previous point's lane value
// (delta prediction) and emits one vector per point.
//   clk, rst : clock, synchronous active-high reset
//   bus      : attr_residual_sequencer_if.slave (frame control, symbol
//              input, vector output)
// Build option: ATTR_RESID_SATURATE_EN clamps lane sums to
// [0, 2^ATTR_WIDTH-1]; without it lane sums wrap. ATTR_WIDTH must be < 32.
//
// state   | meaning
// IDLE    | waiting for start
// COLLECT | accepting NUM_ATTR symbols for the current point
// EMIT    | presenting the reconstructed vector until out_ready
// DONE    | one-cycle done pulse, then back to IDLE
module attr_residual_sequencer
  import attr_seq_pkg::*;
#(
  parameter int SYMBOL_WIDTH = 8,
  parameter int ATTR_WIDTH   = 8,
  parameter int NUM_ATTR     = 3,
  parameter int CNT_WIDTH    = 16
) (
  input logic                     clk,
  input logic                     rst,
  attr_residual_sequencer_if.slave bus
);

  localparam int IDX_W = (NUM_ATTR > 1) ? $clog2(NUM_ATTR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ATTR - 1);
`ifdef ATTR_RESID_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  seq_state_e                         state, state_next;
  logic [NUM_ATTR-1:0][ATTR_WIDTH-1:0] lanes;
  logic [CNT_WIDTH-1:0]               remaining;
  logic [IDX_W-1:0]                   idx;
  logic [ATTR_WIDTH-1:0]              resid;
  logic signed [31:0]                 resid_ext;
  logic [ATTR_WIDTH-1:0]              lane_cur;
  logic [31:0]                        lane_sum;
  logic                               sum_hi_unused;
  logic                               sym_fire;
  logic                               out_fire;
  logic                               frame_go;

  attr_residual_ext #(
    .SYMBOL_WIDTH(SYMBOL_WIDTH),
    .ATTR_WIDTH  (ATTR_WIDTH)
  ) u_ext (
    .sym  (bus.sym_data),
    .resid(resid)
  );

  assign resid_ext     = 32'($signed(resid));
  assign lane_cur      = lanes[idx];
  assign lane_sum      = attr_add(32'(lane_cur), resid_ext, ATTR_WIDTH, SATURATE);
  assign sum_hi_unused = ^lane_sum[31:ATTR_WIDTH];

  assign sym_fire = (state == COLLECT) && bus.sym_valid;
  assign out_fire = (state == EMIT) && bus.out_ready;
  assign frame_go = (state == IDLE) && bus.start && (bus.point_count != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) state_next = (bus.point_count != '0) ? COLLECT : DONE;
      end
      COLLECT: begin
        if (sym_fire && (idx == LAST_IDX)) state_next = EMIT;
      end
      EMIT: begin
        if (out_fire) state_next = (remaining == CNT_WIDTH'(1)) ? DONE : COLLECT;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.sym_ready = (state == COLLECT);
    bus.out_valid = (state == EMIT);
    bus.out_last  = (state == EMIT) && (remaining == CNT_WIDTH'(1));
    bus.done      = (state == DONE);
  end

  // Lanes double as the output register and the predictor for the next point,
  // so they are only cleared on reset or at the start of a frame.
  assign bus.out_attr = lanes;

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes     <= '0;
      remaining <= '0;
      idx       <= '0;
    end else begin
      if (frame_go) begin
        lanes     <= '0;
        remaining <= bus.point_count;
        idx       <= '0;
      end
      if (sym_fire) begin
        lanes[idx] <= lane_sum[ATTR_WIDTH-1:0];
        idx        <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
      if (out_fire) remaining <= remaining - CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_attr_residual_sequencer.sv
module tb_attr_residual_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  attr_residual_sequencer_if #(.SYMBOL_WIDTH(8), .ATTR_WIDTH(8), .NUM_ATTR(3), .CNT_WIDTH(16)) m ();
  attr_residual_sequencer_if #(.SYMBOL_WIDTH(4), .ATTR_WIDTH(8), .NUM_ATTR(3), .CNT_WIDTH(16)) n ();

  attr_residual_sequencer #(.SYMBOL_WIDTH(8), .ATTR_WIDTH(8), .NUM_ATTR(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(m)
  );

  attr_residual_sequencer #(.SYMBOL_WIDTH(4), .ATTR_WIDTH(8), .NUM_ATTR(3), .CNT_WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .bus(n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_sym(input logic [7:0] d);
    int k;
    m.sym_valid = 1'b1;
    m.sym_data  = d;
    k = 0;
    while (!m.sym_ready && k < 20) begin
      tick();
      k++;
    end
    chk("sym_ready_wait", m.sym_ready, 1'b1);
    tick();
    m.sym_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [23:0] ea, input logic el);
    int k;
    k = 0;
    while (!m.out_valid && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, m.out_valid, 1'b1);
    chk({tag, "_attr"}, m.out_attr, ea);
    chk({tag, "_last"}, m.out_last, el);
    m.out_ready = 1'b1;
    tick();
    m.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] exp_wrap;
`ifdef ATTR_RESID_SATURATE_EN
    exp_wrap = 24'h0000FF;
`else
    exp_wrap = 24'h00007D;
`endif
    m.start = 1'b0; m.point_count = '0; m.sym_valid = 1'b0; m.sym_data = '0; m.out_ready = 1'b0;
    n.start = 1'b0; n.point_count = '0; n.sym_valid = 1'b0; n.sym_data = '0; n.out_ready = 1'b0;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", m.busy, 1'b0);
    chk("rst_done", m.done, 1'b0);
    chk("rst_sym_ready", m.sym_ready, 1'b0);
    chk("rst_out_valid", m.out_valid, 1'b0);
    chk("rst_out_last", m.out_last, 1'b0);
    chk("rst_out_attr", m.out_attr, 24'h0);
    rst = 1'b0;
    tick();

    // two-point frame with positive and negative residuals
    m.start = 1'b1; m.point_count = 16'd2;
    tick();
    m.start = 1'b0;
    chk("t1_sym_ready_lat", m.sym_ready, 1'b1);
    chk("t1_busy", m.busy, 1'b1);
    send_sym(8'h0A); send_sym(8'h14); send_sym(8'h1E);
    recv("t1_p1", 24'h1E140A, 1'b0);
    send_sym(8'hFF); send_sym(8'h01); send_sym(8'hFE);
    recv("t1_p2", 24'h1C1509, 1'b1);
    chk("t1_done", m.done, 1'b1);
    tick();
    chk("t1_done_clr", m.done, 1'b0);
    chk("t1_idle", m.busy, 1'b0);

    // lane 0 accumulates 0x7F per point; third point wraps or clamps.
    // First vector is back-pressured for 5 cycles with a symbol offered.
    m.start = 1'b1; m.point_count = 16'd3;
    tick();
    m.start = 1'b0;
    send_sym(8'h7F); send_sym(8'h00); send_sym(8'h00);
    m.sym_valid = 1'b1; m.sym_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", m.out_valid, 1'b1);
      chk("t2_stall_attr", m.out_attr, 24'h00007F);
      chk("t2_stall_sym_ready", m.sym_ready, 1'b0);
      tick();
    end
    m.sym_valid = 1'b0;
    recv("t2_p1", 24'h00007F, 1'b0);
    send_sym(8'h7F); send_sym(8'h00); send_sym(8'h00);
    recv("t2_p2", 24'h0000FE, 1'b0);
    send_sym(8'h7F); send_sym(8'h00); send_sym(8'h00);
    recv("t2_p3", exp_wrap, 1'b1);
    chk("t2_done", m.done, 1'b1);
    tick();

    // empty frame
    m.start = 1'b1; m.point_count = 16'd0;
    tick();
    m.start = 1'b0;
    chk("t3_done", m.done, 1'b1);
    chk("t3_busy", m.busy, 1'b1);
    chk("t3_out_valid", m.out_valid, 1'b0);
    chk("t3_sym_ready", m.sym_ready, 1'b0);
    tick();
    chk("t3_done_clr", m.done, 1'b0);
    chk("t3_idle", m.busy, 1'b0);

    // reset mid-point discards partial lanes
    m.start = 1'b1; m.point_count = 16'd1;
    tick();
    m.start = 1'b0;
    send_sym(8'h05); send_sym(8'h06);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_busy", m.busy, 1'b0);
    chk("t4_rst_sym_ready", m.sym_ready, 1'b0);
    chk("t4_rst_out_attr", m.out_attr, 24'h0);
    chk("t4_rst_done", m.done, 1'b0);

    // new frame starts from zero lanes; start while busy is ignored
    m.start = 1'b1; m.point_count = 16'd1;
    tick();
    m.start = 1'b0;
    send_sym(8'h01);
    m.start = 1'b1; m.point_count = 16'd5;
    send_sym(8'h02);
    m.start = 1'b0; m.point_count = 16'd0;
    send_sym(8'h03);
    recv("t5_p1", 24'h030201, 1'b1);
    chk("t5_done", m.done, 1'b1);
    tick();
    chk("t5_idle", m.busy, 1'b0);

    // 4-bit symbols sign-extend into 8-bit lanes: F -> -1, 7 -> +7, 8 -> -8
    n.start = 1'b1; n.point_count = 16'd1;
    tick();
    n.start = 1'b0;
    chk("t6_sym_ready", n.sym_ready, 1'b1);
    n.sym_valid = 1'b1;
    n.sym_data = 4'hF; tick();
    n.sym_data = 4'h7; tick();
    n.sym_data = 4'h8; tick();
    n.sym_valid = 1'b0;
    chk("t6_out_valid", n.out_valid, 1'b1);
    chk("t6_out_attr", n.out_attr, 24'hF807FF);
    chk("t6_out_last", n.out_last, 1'b1);
    n.out_ready = 1'b1;
    tick();
    n.out_ready = 1'b0;
    chk("t6_done", n.done, 1'b1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
